// File: rtl/fnd_scan_ctrl_pkg.sv
// Shared FND decoder codes and scan types.
// Used by fnd_scan_ctrl and bcd_ctrl.
package fnd_scan_ctrl_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [3:0] BCD_DOT   = 4'hE;
  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic {
    PH_VALUE = 1'b0,
    PH_DOT   = 1'b1
  } phase_e;

endpackage

// File: rtl/fnd_scan_ctrl_tick_gen.sv
// Prescaler: one-cycle tick every DIV clocks.
// Ports: clk, rst_n (sync, active-low), tick.
module tick_gen #(
  parameter int DIV = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int          W    = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/fnd_scan_ctrl.sv
// 4-digit FND scan: value and dot phase per digit.
// In: digit_bcd, dot_en, blink_en, lz_blank. Out: bcd, fnd_com.
import fnd_scan_ctrl_pkg::*;

module fnd_scan_ctrl #(
  parameter int SCAN_DIV    = 100_000,
  parameter int BLINK_TICKS = 250
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   digit_bcd,
  input  logic [NUM_DIGITS-1:0]     dot_en,
  input  logic [NUM_DIGITS-1:0]     blink_en,
  input  logic                      lz_blank,
  output logic [3:0]                bcd,
  output logic [NUM_DIGITS-1:0]     fnd_com
);

  localparam int BW = (BLINK_TICKS > 1) ?
                      $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_TICKS - 1);

  logic          w_tick;
  logic [2:0]    r_slot;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_off;

  logic [1:0]    w_d;
  phase_e        w_phase;
  logic [3:0]    w_dig;
  logic [3:0]    w_lz;
  logic          w_bb;
  logic [3:0]    w_bcd_nxt;
  logic [3:0]    w_com_nxt;

  tick_gen #(
    .DIV (SCAN_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  assign w_d     = r_slot[2:1];
  assign w_phase = phase_e'(r_slot[0]);
  assign w_dig   = digit_bcd[{w_d, 2'b00} +: 4];

  // A digit is a leading zero only if it and
  // every digit to its left are zero.
  assign w_lz[3] = lz_blank & (digit_bcd[15:12] == 4'h0);
  assign w_lz[2] = w_lz[3]  & (digit_bcd[11:8]  == 4'h0);
  assign w_lz[1] = w_lz[2]  & (digit_bcd[7:4]   == 4'h0);
  assign w_lz[0] = 1'b0;

  assign w_bb      = r_blink_off & blink_en[w_d];
  assign w_com_nxt = ~(4'b0001 << w_d);

  always_comb begin
    w_bcd_nxt = BCD_BLANK;
    unique case (w_phase)
      PH_VALUE: begin
        if (!(w_bb || w_lz[w_d])) begin
          w_bcd_nxt = w_dig;
        end
      end
      PH_DOT: begin
        if (dot_en[w_d] && !w_bb) begin
          w_bcd_nxt = BCD_DOT;
        end
      end
      default: w_bcd_nxt = BCD_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_slot      <= '0;
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
      bcd         <= BCD_BLANK;
      fnd_com     <= '1;
    end else begin
      if (w_tick) begin
        r_slot <= r_slot + 3'd1;
        if (r_blink_cnt == B_LAST) begin
          r_blink_cnt <= '0;
          r_blink_off <= ~r_blink_off;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end
      // Outputs use the pre-increment slot.
      bcd     <= w_bcd_nxt;
      fnd_com <= w_com_nxt;
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl.
// SCAN_DIV=4, BLINK_TICKS=2.
module tb_fnd_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] digit_bcd;
  logic [3:0]  dot_en;
  logic [3:0]  blink_en;
  logic        lz_blank;
  logic [3:0]  bcd;
  logic [3:0]  fnd_com;

  int n_chk;
  int n_fail;

  logic [31:0] com_tab;

  fnd_scan_ctrl #(
    .SCAN_DIV    (4),
    .BLINK_TICKS (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digit_bcd (digit_bcd),
    .dot_en    (dot_en),
    .blink_en  (blink_en),
    .lz_blank  (lz_blank),
    .bcd       (bcd),
    .fnd_com   (fnd_com)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [3:0] got,
                     input logic [3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    chk("rst_bcd", bcd, 4'hF);
    chk("rst_com", fnd_com, 4'hF);
    step();
    step();
    rst_n = 1'b1;
  endtask

  // eb holds expected bcd per slot, nibble s = slot s.
  task automatic run_slots(input string tag,
                           input logic [31:0] eb,
                           input int first,
                           input int last);
    for (int s = first; s <= last; s++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        chk({tag, "_bcd"}, bcd, eb[s*4 +: 4]);
        chk({tag, "_com"}, fnd_com, com_tab[s*4 +: 4]);
      end
    end
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    com_tab   = 32'h77BBDDEE;
    rst_n     = 1'b0;
    digit_bcd = 16'h1234;
    dot_en    = 4'b0100;
    blink_en  = 4'b0000;
    lz_blank  = 1'b0;

    do_reset();
    run_slots("basic", 32'hF1E2F3F4, 0, 7);
    run_slots("wrap", 32'hF1E2F3F4, 0, 7);

    run_slots("pre", 32'hF1E2F3F4, 0, 4);
    step();
    chk("slot5_bcd", bcd, 4'hE);
    chk("slot5_com", fnd_com, 4'hB);
    do_reset();
    run_slots("post", 32'hF1E2F3F4, 0, 7);

    digit_bcd = 16'h0007;
    lz_blank  = 1'b1;
    dot_en    = 4'b1000;
    run_slots("lz7", 32'hEFFFFFF7, 0, 7);

    digit_bcd = 16'h0000;
    dot_en    = 4'b0000;
    run_slots("lz0", 32'hFFFFFFF0, 0, 7);

    digit_bcd = 16'h0100;
    run_slots("lz100", 32'hFFF1F0F0, 0, 7);

    digit_bcd = 16'hABCD;
    dot_en    = 4'b1111;
    run_slots("hex", 32'hEAEBECED, 0, 7);

    // Blink phase equals tick-count bit 1, so in
    // frame-aligned runs d0 is on and d1 is off.
    digit_bcd = 16'h0087;
    lz_blank  = 1'b0;
    dot_en    = 4'b0011;
    blink_en  = 4'b0011;
    run_slots("blink", 32'hF0F0FFE7, 0, 7);
    run_slots("blink2", 32'hF0F0FFE7, 0, 7);

    blink_en  = 4'b0000;
    dot_en    = 4'b0000;
    digit_bcd = 16'h0003;
    step();
    chk("chg0_bcd", bcd, 4'h3);
    digit_bcd = 16'h0005;
    step();
    chk("chg1_bcd", bcd, 4'h5);
    chk("chg1_com", fnd_com, 4'hE);
    step();
    step();
    chk("chg3_com", fnd_com, 4'hE);
    run_slots("chg", 32'hF0F0F0F5, 1, 7);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
